pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Supervises the ECP5 `EHXPLLL` that generates the system, I/O and SDRAM clocks. It runs on the 25 MHz board clock, drives the PLL `RST`, and qualifies and debounces the PLL `LOCK` output. It releases the SDRAM, system and I/O domain resets in a fixed staggered order, re-sequences them on loss of lock or soft reset, and raises a sticky fault after repeated lock timeouts.

## Interface
- `PLLRST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT_CYCLES`, 262144: cycles allowed in WAIT_LOCK before a retry (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required (≥2).
- `STAGGER_CYCLES`, 64: gap between successive domain reset releases (≥2).
- `MAX_ATTEMPTS`, 3: lock timeouts tolerated before FAULT (≥1).
- `clock` in 1: 25 MHz board clock.
- `resetn` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL `LOCK`, asynchronous to `clock`.
- `soft_reset` in 1: one-cycle request to re-sequence the domain resets; honoured only in RUN.
- `pll_rst` out 1: drives PLL `RST`, active high.
- `rst_sdram_n`, `rst_system_n`, `rst_io_n` out 1 each: active-low domain resets. Each consumer synchronizes its own deassertion.
- `ready` out 1: high only in RUN.
- `fault` out 1: sticky lock failure.
- `relock_count` out 8: number of lock losses after stabilization, saturating at 255.

## Operation
- `locked` passes through a 2-flop synchronizer to produce `locked_s`.
- Each timed state has one shared counter. It is cleared on entry and the state is left when the counter reaches N−1, so the state lasts exactly N cycles.
- All outputs are registered, decoded from the next state, and change on the same edge as the state.
- States:
  - PLL_RESET: `pll_rst`=1. Lasts PLLRST_CYCLES, then goes to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0.
    - `locked_s`=1 → STABILIZE.
    - Timeout reached → `attempts`++. If `attempts`==MAX_ATTEMPTS → FAULT, otherwise → PLL_RESET.
  - STABILIZE:
    - `locked_s`=0 → WAIT_LOCK (timeout counter restarts).
    - LOCK_STABLE_CYCLES elapsed → RELEASE_SDRAM, and `attempts` clears.
  - RELEASE_SDRAM: `rst_sdram_n`=1. After STAGGER_CYCLES → RELEASE_SYSTEM.
  - RELEASE_SYSTEM: additionally `rst_system_n`=1. After STAGGER_CYCLES → RELEASE_IO.
  - RELEASE_IO: additionally `rst_io_n`=1. After STAGGER_CYCLES → RUN.
  - RUN: all domain resets released, `ready`=1.
  - FAULT: `fault`=1, `pll_rst`=0, all domain resets asserted. Exit only via `resetn`.
- Lock loss (`locked_s`=0) in any RELEASE_* state or RUN:
  - All domain resets assert and `ready` drops on the next edge.
  - `relock_count`++ (saturating at 255).
  - State → WAIT_LOCK. No PLL reset is issued; the PLL relocks on its own.
- `soft_reset` in RUN: all domain resets assert, state → STABILIZE, `relock_count` unchanged.
- Lock loss in the same cycle as `soft_reset`: lock loss wins.
- `soft_reset` in any other state is ignored.

## Timing
- Reset values:
  - state PLL_RESET, `pll_rst`=1.
  - `rst_*_n`=0, `ready`=0, `fault`=0.
  - `relock_count`=0, `attempts`=0, counters 0.
- Latency from `locked` to `locked_s` is 2 cycles. Lock loss therefore asserts the domain resets 3 edges after the `locked` fall.
- Edge 1 is the first rising edge with `resetn` high. With `locked` already high:
  - PLL_RESET covers edges 1..PLLRST_CYCLES.
  - WAIT_LOCK takes 1 cycle.
  - STABILIZE takes LOCK_STABLE_CYCLES.
  - The releases follow, each STAGGER_CYCLES apart.
- Reset order is always SDRAM, then system, then I/O on release. All three assert together.
- `resetn` asserted mid-sequence → every output returns to its reset value asynchronously.
- Counter width is `$clog2` of the largest timed parameter. `attempts` is `$clog2(MAX_ATTEMPTS+1)` bits wide.

## Structure
- Package `pll_supervisor_pkg`: state enum (PLL_RESET, WAIT_LOCK, STABILIZE, RELEASE_SDRAM, RELEASE_SYSTEM, RELEASE_IO, RUN, FAULT) and the `relock_count` width constant.
- One sub-module, `sync2_bit`: the 2-flop synchronizer with asynchronous active-low reset, reset value 0.

## Test plan
All scenarios use PLLRST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=4, MAX_ATTEMPTS=2.

1. `locked`=1 from reset:
   - `pll_rst` falls at edge 4.
   - `rst_sdram_n` rises at edge 13, `rst_system_n` at 17, `rst_io_n` at 21.
   - `ready` rises at edge 25.
2. `locked`=0 throughout:
   - `pll_rst` re-asserts at edge 36.
   - `fault`=1 at edge 72, with all domain resets low and `pll_rst`=0 thereafter.
3. `locked` glitches low for 1 cycle during STABILIZE → return to WAIT_LOCK, then STABILIZE restarts for a full 8 cycles; `relock_count` stays 0.
4. `locked` drops in RUN → all resets low and `ready`=0 three edges later, `relock_count`=1. `locked` returns → full release sequence repeats without `pll_rst`.
5. `soft_reset` pulse in RUN → resets assert next edge; SDRAM released 8 cycles later, `ready` 20 cycles later. The same pulse outside RUN has no effect.
6. `resetn` pulsed low during RELEASE_SYSTEM → all outputs return to reset values immediately. Force 300 lock losses → `relock_count` saturates at 255.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// rtl/pll_supervisor_pkg.sv - shared types and constants for the PLL lock supervisor
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        PLL_RESET      = 3'd0,
        WAIT_LOCK      = 3'd1,
        STABILIZE      = 3'd2,
        RELEASE_SDRAM  = 3'd3,
        RELEASE_SYSTEM = 3'd4,
        RELEASE_IO     = 3'd5,
        RUN            = 3'd6,
        FAULT          = 3'd7
    } sup_state_e;

    localparam int RELOCK_W = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync2_bit.sv
// rtl/sync2_bit.sv - two-flop synchronizer, async active-low reset to 0
module sync2_bit (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock qualification and staggered domain reset release
module pll_lock_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int PLLRST_CYCLES       = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 262144,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 64,
    parameter int MAX_ATTEMPTS        = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                locked,
    input  logic                soft_reset,
    output logic                pll_rst,
    output logic                rst_sdram_n,
    output logic                rst_system_n,
    output logic                rst_io_n,
    output logic                ready,
    output logic                fault,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int MAX_TIMED = max4(PLLRST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                    LOCK_STABLE_CYCLES, STAGGER_CYCLES);
    localparam int CNT_W = $clog2(MAX_TIMED);
    localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLLRST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [ATT_W-1:0] ATT_LIMIT    = ATT_W'(MAX_ATTEMPTS);

    logic                locked_s;
    sup_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ATT_W-1:0]    attempts_q, attempts_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;

    sync2_bit u_lock_sync (
        .clk_i  (clock),
        .rst_ni (resetn),
        .d_i    (locked),
        .q_o    (locked_s)
    );

    always_comb begin
        state_d    = state_q;
        attempts_d = attempts_q;
        relock_d   = relock_q;
        cnt_d      = cnt_q + CNT_W'(1);
        case (state_q)
            PLL_RESET: begin
                if (cnt_q == PLLRST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    attempts_d = attempts_q + ATT_W'(1);
                    state_d    = (attempts_d == ATT_LIMIT) ? FAULT : PLL_RESET;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    attempts_d = '0;
                    state_d    = RELEASE_SDRAM;
                end
            end
            RELEASE_SDRAM, RELEASE_SYSTEM, RELEASE_IO, RUN: begin
                // Lock loss outranks a coincident soft reset; the PLL relocks without RST.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    if (relock_q != '1) relock_d = relock_q + RELOCK_W'(1);
                end else if (state_q == RUN) begin
                    if (soft_reset) state_d = STABILIZE;
                end else if (cnt_q == STAGGER_LAST) begin
                    case (state_q)
                        RELEASE_SDRAM:  state_d = RELEASE_SYSTEM;
                        RELEASE_SYSTEM: state_d = RELEASE_IO;
                        default:        state_d = RUN;
                    endcase
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RESET;
            end
        endcase
        if (state_d != state_q || state_q == RUN || state_q == FAULT) cnt_d = '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= PLL_RESET;
            cnt_q        <= '0;
            attempts_q   <= '0;
            relock_q     <= '0;
            pll_rst      <= 1'b1;
            rst_sdram_n  <= 1'b0;
            rst_system_n <= 1'b0;
            rst_io_n     <= 1'b0;
            ready        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            attempts_q   <= attempts_d;
            relock_q     <= relock_d;
            pll_rst      <= (state_d == PLL_RESET);
            rst_sdram_n  <= (state_d inside {RELEASE_SDRAM, RELEASE_SYSTEM, RELEASE_IO, RUN});
            rst_system_n <= (state_d inside {RELEASE_SYSTEM, RELEASE_IO, RUN});
            rst_io_n     <= (state_d inside {RELEASE_IO, RUN});
            ready        <= (state_d == RUN);
            fault        <= (state_d == FAULT);
        end
    end

    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - randomized and directed bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    localparam int P_RST  = 4;
    localparam int P_TO   = 32;
    localparam int P_STAB = 8;
    localparam int P_STAG = 4;
    localparam int P_MAX  = 2;

    localparam int PH_PLLRST = 0;
    localparam int PH_SEEK   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_REL_A  = 3;
    localparam int PH_REL_B  = 4;
    localparam int PH_REL_C  = 5;
    localparam int PH_RUN    = 6;
    localparam int PH_DEAD   = 7;

    logic       clock      = 1'b0;
    logic       resetn     = 1'b1;
    logic       locked     = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pll_rst;
    logic       rst_sdram_n;
    logic       rst_system_n;
    logic       rst_io_n;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;

    int tests = 0;
    int fails = 0;
    int printed = 0;

    pll_lock_supervisor #(
        .PLLRST_CYCLES       (P_RST),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .LOCK_STABLE_CYCLES  (P_STAB),
        .STAGGER_CYCLES      (P_STAG),
        .MAX_ATTEMPTS        (P_MAX)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .locked       (locked),
        .soft_reset   (soft_reset),
        .pll_rst      (pll_rst),
        .rst_sdram_n  (rst_sdram_n),
        .rst_system_n (rst_system_n),
        .rst_io_n     (rst_io_n),
        .ready        (ready),
        .fault        (fault),
        .relock_count (relock_count)
    );

    always #20 clock = ~clock;

    // Reference: phase plus the edge at which it was entered; a phase of N cycles ends at entry+N.
    int m_ph     = PH_PLLRST;
    int m_entry  = 0;
    int m_edge   = 0;
    int m_att    = 0;
    int m_relock = 0;
    bit ms1      = 1'b0;
    bit ms2      = 1'b0;

    initial forever begin : model
        bit ls;
        int age;
        int nxt;
        @(posedge clock or negedge resetn);
        if (!resetn) begin
            m_ph = PH_PLLRST; m_entry = 0; m_edge = 0;
            m_att = 0; m_relock = 0; ms1 = 1'b0; ms2 = 1'b0;
        end else begin
            m_edge++;
            ls  = ms2;
            ms2 = ms1;
            ms1 = locked;
            age = m_edge - m_entry;
            nxt = m_ph;
            if (m_ph == PH_PLLRST) begin
                if (age == P_RST) nxt = PH_SEEK;
            end else if (m_ph == PH_SEEK) begin
                if (ls) nxt = PH_SETTLE;
                else if (age == P_TO) begin
                    m_att++;
                    nxt = (m_att == P_MAX) ? PH_DEAD : PH_PLLRST;
                end
            end else if (m_ph == PH_SETTLE) begin
                if (!ls) nxt = PH_SEEK;
                else if (age == P_STAB) begin
                    m_att = 0;
                    nxt = PH_REL_A;
                end
            end else if (m_ph != PH_DEAD) begin
                if (!ls) begin
                    nxt = PH_SEEK;
                    if (m_relock < 255) m_relock++;
                end else if (m_ph == PH_RUN) begin
                    if (soft_reset) nxt = PH_SETTLE;
                end else if (age == P_STAG) begin
                    nxt = m_ph + 1;
                end
            end
            if (nxt != m_ph) begin
                m_ph = nxt;
                m_entry = m_edge;
            end
        end
    end

    initial forever begin : compare
        logic [13:0] act_v;
        logic [13:0] exp_v;
        @(negedge clock);
        act_v = {pll_rst, rst_sdram_n, rst_system_n, rst_io_n, ready, fault, relock_count};
        exp_v = {m_ph == PH_PLLRST,
                 m_ph >= PH_REL_A && m_ph <= PH_RUN,
                 m_ph >= PH_REL_B && m_ph <= PH_RUN,
                 m_ph >= PH_REL_C && m_ph <= PH_RUN,
                 m_ph == PH_RUN,
                 m_ph == PH_DEAD,
                 8'(m_relock)};
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            if (printed < 20) begin
                printed++;
                $display("FAIL cycle_model edge=%0d got=%b expected=%b (pll,sd,sys,io,rdy,flt,relock)",
                         m_edge, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_edge(input int e);
        int guard = 0;
        while (m_edge < e && guard < 20000) begin
            @(negedge clock);
            guard++;
        end
        if (m_edge != e) begin
            tests++;
            fails++;
            $display("FAIL wait_edge: at edge %0d, wanted %0d", m_edge, e);
        end
    endtask

    task automatic do_reset(input logic lk);
        @(negedge clock);
        #5;
        resetn     = 1'b0;
        locked     = lk;
        soft_reset = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int hold;
        #1 resetn = 1'b0;

        // Locked from reset: release timeline
        do_reset(1'b1);
        wait_edge(3);  chk("s1_pll_rst_e3", pll_rst, 1);
        wait_edge(4);  chk("s1_pll_rst_e4", pll_rst, 0);
        wait_edge(12); chk("s1_sdram_e12", rst_sdram_n, 0);
        wait_edge(13); chk("s1_sdram_e13", rst_sdram_n, 1); chk("s1_system_e13", rst_system_n, 0);
        wait_edge(16); chk("s1_system_e16", rst_system_n, 0);
        wait_edge(17); chk("s1_system_e17", rst_system_n, 1);
        wait_edge(20); chk("s1_io_e20", rst_io_n, 0);
        wait_edge(21); chk("s1_io_e21", rst_io_n, 1);
        wait_edge(24); chk("s1_ready_e24", ready, 0);
        wait_edge(25); chk("s1_ready_e25", ready, 1);
        wait_edge(30); chk("s1_fault", fault, 0); chk("s1_relock", relock_count, 0);

        // Never locked: retry then fault
        do_reset(1'b0);
        wait_edge(35);  chk("s2_pll_rst_e35", pll_rst, 0);
        wait_edge(36);  chk("s2_pll_rst_e36", pll_rst, 1);
        wait_edge(39);  chk("s2_pll_rst_e39", pll_rst, 1);
        wait_edge(40);  chk("s2_pll_rst_e40", pll_rst, 0);
        wait_edge(71);  chk("s2_fault_e71", fault, 0);
        wait_edge(72);  chk("s2_fault_e72", fault, 1); chk("s2_pll_rst_e72", pll_rst, 0);
        wait_edge(100); chk("s2_fault_hold", fault, 1); chk("s2_sdram_hold", rst_sdram_n, 0);

        // One-cycle glitch during STABILIZE
        do_reset(1'b1);
        wait_edge(7);  locked = 1'b0;
        wait_edge(8);  locked = 1'b1;
        wait_edge(18); chk("s3_sdram_e18", rst_sdram_n, 0);
        wait_edge(19); chk("s3_sdram_e19", rst_sdram_n, 1); chk("s3_relock", relock_count, 0);

        // Lock loss in RUN, relock, soft resets, loss-versus-soft priority
        do_reset(1'b1);
        wait_edge(30); locked = 1'b0;
        wait_edge(32); chk("s4_ready_e32", ready, 1);
        wait_edge(33); chk("s4_ready_e33", ready, 0); chk("s4_sdram_e33", rst_sdram_n, 0);
                       chk("s4_io_e33", rst_io_n, 0); chk("s4_relock_e33", relock_count, 1);
                       chk("s4_pll_rst_e33", pll_rst, 0);
        wait_edge(35); locked = 1'b1;
        wait_edge(45); chk("s4_sdram_e45", rst_sdram_n, 0);
        wait_edge(46); chk("s4_sdram_e46", rst_sdram_n, 1);
        wait_edge(57); chk("s4_ready_e57", ready, 0);
        wait_edge(58); chk("s4_ready_e58", ready, 1);
        wait_edge(60); soft_reset = 1'b1;
        wait_edge(61); soft_reset = 1'b0;
                       chk("s5_sdram_e61", rst_sdram_n, 0); chk("s5_ready_e61", ready, 0);
                       chk("s5_relock_e61", relock_count, 1);
        wait_edge(68); chk("s5_sdram_e68", rst_sdram_n, 0);
        wait_edge(69); chk("s5_sdram_e69", rst_sdram_n, 1);
        wait_edge(70); soft_reset = 1'b1;
        wait_edge(71); soft_reset = 1'b0;
        wait_edge(80); chk("s5_ready_e80", ready, 0);
        wait_edge(81); chk("s5_ready_e81", ready, 1); chk("s5_relock_e81", relock_count, 1);
        wait_edge(90); locked = 1'b0;
        wait_edge(92); soft_reset = 1'b1;
        wait_edge(93); soft_reset = 1'b0; locked = 1'b1;
                       chk("s5_relock_e93", relock_count, 2); chk("s5_sdram_e93", rst_sdram_n, 0);
        wait_edge(115); chk("s5_ready_e115", ready, 0);
        wait_edge(116); chk("s5_ready_e116", ready, 1);

        // Async reset mid-release, then relock_count saturation
        do_reset(1'b1);
        wait_edge(18);
        #5 resetn = 1'b0;
        #1;
        chk("s6_rst_pll", pll_rst, 1);
        chk("s6_rst_sdram", rst_sdram_n, 0);
        chk("s6_rst_system", rst_system_n, 0);
        chk("s6_rst_io", rst_io_n, 0);
        chk("s6_rst_ready", ready, 0);
        chk("s6_rst_fault", fault, 0);
        chk("s6_rst_relock", relock_count, 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat (14) @(negedge clock);
            locked = 1'b0;
            repeat (4) @(negedge clock);
            locked = 1'b1;
        end
        repeat (5) @(negedge clock);
        chk("s6_relock_sat", relock_count, 255);

        // Randomized lock behaviour and soft resets
        for (int s = 0; s < 4; s++) begin
            do_reset(1'($urandom_range(0, 1)));
            hold = 0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clock);
                if (hold == 0) begin
                    locked = ~locked;
                    if (locked) hold = $urandom_range(1, 60);
                    else if ($urandom_range(0, 3) == 0) hold = $urandom_range(30, 90);
                    else hold = $urandom_range(1, 6);
                end else begin
                    hold--;
                end
                soft_reset = ($urandom_range(0, 5) == 0);
            end
            soft_reset = 1'b0;
        end

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
